wallace_merge_seq_cpa: RTL and testbench
========================================

Name: wallace_merge_seq_cpa

Overview:
- Sequential final stage of the FPU_MUL Wallace tree.
- Takes the tree's redundant outputs (sum vector, carry vector, correction vector M) and compresses them with one 3:2 CSA row.
- Resolves the result to a binary product with a segmented, multi-cycle carry-propagate adder.
- Uses a valid/ready handshake on both sides, so it can sit between the Wallace tree and the normaliser/rounder, trading latency for a short critical path.

Parameters:
- WIDTH, 48: width of every input vector and of the product.
- SEG_W, 12: CPA segment width in bits. Must divide WIDTH exactly, otherwise elaboration fails with $error.
- NUM_SEG, WIDTH/SEG_W: derived (localparam); number of CPA cycles.
- STICKY_W, 23: number of product LSBs ORed into the sticky bit. Used only with STICKY_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input vectors valid
- in_ready  out  1  block can accept an input
- in_sum  in  WIDTH  Wallace final sum vector
- in_carry  in  WIDTH  Wallace final carry vector (already weight-aligned)
- in_m  in  WIDTH  correction vector M
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_product  out  WIDTH  (in_sum + in_carry + in_m) mod 2^WIDTH
- out_ovf  out  1  true sum >= 2^WIDTH
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is sampled on the clock edge and has priority over everything. Resulting values:
  - state = IDLE
  - out_valid = 0, out_product = 0, out_ovf = 0
  - internal S/C registers, segment index and carry flops all 0
- Reset mid-operation (ADD or DONE) aborts the operation. No out_valid is ever produced for it.
- FSM states: IDLE, ADD, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready. On accept:
  - S <= in_sum ^ in_carry ^ in_m.
  - maj = bitwise majority of the three inputs.
  - C <= {maj[WIDTH-2:0], 1'b0}.
  - cmsb <= maj[WIDTH-1].
  - seg = 0, cin = 0, state -> ADD.
- ADD: each cycle adds segment seg: {cout, R[seg]} = S[seg] + C[seg] + cin.
  - cin <= cout; seg <= seg + 1.
  - On the cycle with seg == NUM_SEG-1:
    - out_product <= final R;
    - out_ovf <= cmsb | cout;
    - state -> DONE; out_valid <= 1.
- Latency: out_valid first high exactly NUM_SEG+1 cycles after the accept cycle (5 with the defaults).
- Throughput: one result per NUM_SEG+1 cycles with no backpressure.
- DONE:
  - out_valid = 1; out_product and out_ovf held stable until out_valid & out_ready.
  - Handshake with no new accept: state -> IDLE, out_valid <= 0.
  - Handshake with a simultaneous accept: state -> ADD directly, with the new operands loaded as on accept. No idle bubble.
- out_product and out_ovf are don't-care while out_valid = 0. They are not updated during ADD.
- in_valid while state == ADD is ignored (in_ready = 0). Upstream holds its data.
- Arithmetic: all unsigned, modulo 2^WIDTH, plus the overflow flag. No sign handling.

Optional Feature:
- Macro: WALLACE_MERGE_STICKY_EN.
- Defined:
  - Adds output out_sticky (1 bit) = OR of the product bits [STICKY_W-1:0], registered together with out_product.
  - Reset value 0; held with out_product in DONE.
  - Computed incrementally per segment, ORed into a sticky flop cleared on accept. No WIDTH-wide OR in one cycle.
- Not defined: port out_sticky and its logic are absent; STICKY_W is unused.

Test Plan:
1. rst = 1 for 2 cycles, then 0 -> out_valid = 0, in_ready = 1, busy = 0, out_product = 0, out_ovf = 0.
2. in_sum = 1, in_carry = 2, in_m = 3, out_ready = 1 -> out_valid rises exactly 5 cycles after accept, out_product = 6, out_ovf = 0, out_sticky = 1 (sticky build).
3. in_sum = 0xFFFFFFFFFFFF, in_carry = 0, in_m = 1 -> carry ripples through all 4 segments: out_product = 0, out_ovf = 1, out_sticky = 0.
4. All three inputs = 0xFFFFFFFFFFFF -> out_product = 0xFFFFFFFFFFFD, out_ovf = 1 (both cmsb and CPA carry set).
5. Backpressure: hold out_ready = 0 for 3 cycles in DONE -> out_valid stays 1, product stable, in_ready = 0. Then raise out_ready together with in_valid (operands 5, 5, 5) -> accepted the same cycle, next out_product = 15 exactly 5 cycles later, no IDLE cycle.
6. Pulse rst for 1 cycle 2 cycles after an accept -> state IDLE next cycle, out_valid never rises for that operation, and the next operation produces a correct result.

Source files
------------

// File: rtl/wallace_merge_seq_cpa.sv
// Final Wallace-tree stage: one 3:2 CSA row, then a segmented multi-cycle CPA behind valid/ready.
// Optional macro WALLACE_MERGE_STICKY_EN adds out_sticky (OR of product bits [STICKY_W-1:0]).
module wallace_merge_seq_cpa #(
   parameter int WIDTH    = 48,
`ifdef WALLACE_MERGE_STICKY_EN
   parameter int STICKY_W = 23,
`endif
   parameter int SEG_W    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   input  logic [WIDTH-1:0] in_m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product,
   output logic             out_ovf,
`ifdef WALLACE_MERGE_STICKY_EN
   output logic             out_sticky,
`endif
   output logic             busy
);

   localparam int NUM_SEG   = WIDTH / SEG_W;
   localparam int SEG_IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(NUM_SEG - 1);

   if (WIDTH % SEG_W != 0) begin : g_bad_seg_w
      $error("wallace_merge_seq_cpa: SEG_W (%0d) must divide WIDTH (%0d)", SEG_W, WIDTH);
   end

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t               r_state, w_next_state;
   logic [WIDTH-1:0]     r_s, r_c, r_product;
   logic                 r_cmsb, r_cin, r_ovf, r_out_valid;
   logic [SEG_IDX_W-1:0] r_seg;

   logic                 w_accept, w_last;
   logic [WIDTH-1:0]     w_maj, w_result;
   logic [SEG_W-1:0]     w_seg_s, w_seg_c;
   logic [SEG_W:0]       w_seg_add;
   logic                 w_cout;

   assign in_ready    = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign w_accept    = in_valid & in_ready;
   assign w_last      = (r_state == ADD) && (r_seg == LAST_SEG);
   assign busy        = (r_state != IDLE);
   assign out_valid   = r_out_valid;
   assign out_product = r_product;
   assign out_ovf     = r_ovf;

   assign w_maj = (in_sum & in_carry) | (in_sum & in_m) | (in_carry & in_m);

   // One segment per cycle; the segment's R overwrites its S bits so r_s ends up holding the product.
   assign w_seg_s   = r_s[int'(r_seg)*SEG_W +: SEG_W];
   assign w_seg_c   = r_c[int'(r_seg)*SEG_W +: SEG_W];
   assign w_seg_add = {1'b0, w_seg_s} + {1'b0, w_seg_c} + {{SEG_W{1'b0}}, r_cin};
   assign w_cout    = w_seg_add[SEG_W];

   always_comb begin
      // NOTE: default first so no path leaves a combinational output unassigned (no latch).
      w_result = r_s;
      w_result[int'(r_seg)*SEG_W +: SEG_W] = w_seg_add[SEG_W-1:0];
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next_state = ADD;
         ADD:  if (w_last)   w_next_state = DONE;
         DONE: if (out_ready) w_next_state = w_accept ? ADD : IDLE;
         default:            w_next_state = IDLE;
      endcase
   end

`ifdef WALLACE_MERGE_STICKY_EN
   logic r_sticky_acc, r_sticky, w_seg_sticky;

   // Only bits whose global index falls below STICKY_W contribute from the current segment.
   always_comb begin
      w_seg_sticky = 1'b0;
      for (int j = 0; j < SEG_W; j++) begin
         if (int'(r_seg) * SEG_W + j < STICKY_W) w_seg_sticky = w_seg_sticky | w_seg_add[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky_acc <= 1'b0;
         r_sticky     <= 1'b0;
      end else if (w_accept) begin
         r_sticky_acc <= 1'b0;
      end else if (r_state == ADD) begin
         r_sticky_acc <= r_sticky_acc | w_seg_sticky;
         if (w_last) r_sticky <= r_sticky_acc | w_seg_sticky;
      end
   end

   assign out_sticky = r_sticky;
`endif

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_state     <= IDLE;
         r_s         <= '0;
         r_c         <= '0;
         r_cmsb      <= 1'b0;
         r_cin       <= 1'b0;
         r_seg       <= '0;
         r_product   <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_s    <= in_sum ^ in_carry ^ in_m;
            r_c    <= {w_maj[WIDTH-2:0], 1'b0};
            r_cmsb <= w_maj[WIDTH-1];
            r_cin  <= 1'b0;
            r_seg  <= '0;
         end else if (r_state == ADD) begin
            r_s   <= w_result;
            r_cin <= w_cout;
            r_seg <= r_seg + 1'b1;
            if (w_last) begin
               r_product <= w_result;
               r_ovf     <= r_cmsb | w_cout;
            end
         end
         if (w_last)
            r_out_valid <= 1'b1;
         else if ((r_state == DONE) && out_ready)
            r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wallace_merge_seq_cpa.sv
// Directed self-checking bench for wallace_merge_seq_cpa (default 48-bit, 12-bit segments).
module tb_wallace_merge_seq_cpa;

   localparam int W = 48;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
   logic [W-1:0] in_sum, in_carry, in_m, out_product;
`ifdef WALLACE_MERGE_STICKY_EN
   logic         out_sticky;
`endif

   int tests = 0;
   int fails = 0;

   wallace_merge_seq_cpa dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_carry   (in_carry),
      .in_m       (in_m),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .out_ovf    (out_ovf),
`ifdef WALLACE_MERGE_STICKY_EN
      .out_sticky (out_sticky),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W-1:0] m);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      in_m     = m;
   endtask

   // Accept cycle is cycle 0; out_valid must first be seen in cycle 5 (four edges past the accept edge).
   task automatic wait_result(input string tag, input logic [W-1:0] exp_p, input logic exp_o);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check({tag, "_no_valid"}, 64'(out_valid), 64'd0);
         check({tag, "_in_ready_add"}, 64'(in_ready), 64'd0);
      end
      tick();
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_product"}, 64'(out_product), 64'(exp_p));
      check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_o));
`ifdef WALLACE_MERGE_STICKY_EN
      check({tag, "_sticky"}, 64'(out_sticky), 64'(|exp_p[22:0]));
`endif
   endtask

   // Full operation from IDLE with out_ready = 1, ending back in IDLE.
   task automatic run_op(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                         input logic [W-1:0] m, input logic [W-1:0] exp_p, input logic exp_o);
      drive(s, c, m);
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_result(tag, exp_p, exp_o);
      tick();
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [W-1:0] held;
      int           seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_sum = '0; in_carry = '0; in_m = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_product", 64'(out_product), 64'd0);
      check("rst_ovf", 64'(out_ovf), 64'd0);

      run_op("small", 48'd1, 48'd2, 48'd3, 48'd6, 1'b0);
      run_op("ripple", 48'hFFFF_FFFF_FFFF, 48'd0, 48'd1, 48'd0, 1'b1);
      run_op("all_ones", 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
             48'hFFFF_FFFF_FFFD, 1'b1);
      run_op("seg_cross", 48'h0000_0000_0FFF, 48'd1, 48'd0, 48'h0000_0000_1000, 1'b0);
      run_op("cmsb_only", 48'h8000_0000_0000, 48'h8000_0000_0000, 48'd0, 48'd0, 1'b1);

      // Backpressure: result held in DONE, then handshake and new accept in the same cycle.
      out_ready = 1'b0;
      drive(48'h1234_5678_9ABC, 48'h1111_1111_1111, 48'd0);
      tick();
      in_valid = 1'b0;
      wait_result("bp", 48'h2345_6789_ABCD, 1'b0);
      held = out_product;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_product", 64'(out_product), 64'h2345_6789_ABCD);
         check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      drive(48'd5, 48'd5, 48'd5);
      #1;
      check("bp_in_ready_release", 64'(in_ready), 64'd1);
      check("bp_product_at_release", 64'(out_product), 64'(held));
      tick();
      in_valid = 1'b0;
      check("bp_no_bubble_busy", 64'(busy), 64'd1);
      check("bp_valid_cleared", 64'(out_valid), 64'd0);
      wait_result("b2b", 48'd15, 1'b0);
      tick();
      check("b2b_idle", 64'(busy), 64'd0);

      // Reset two cycles after accept aborts the operation.
      drive(48'd100, 48'd200, 48'd300);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seen++;
         tick();
      end
      check("abort_no_valid", 64'(seen), 64'd0);
      run_op("after_abort", 48'd100, 48'd200, 48'd300, 48'd600, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
